load_store_unit: RTL and testbench

//  Sits between execute and data memory. Accepts one load/store request per transaction (valid/ready).

---
 rtl/load_store_unit_pkg.sv | 17 +
 rtl/load_store_unit_addr_gen.sv | 30 +++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - size codes and FSM state encoding shared by the load/store unit
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_INV  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_LD = 3'd1,
        ST_WAIT_LD  = 3'd2,
        ST_ISSUE_ST = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_addr_gen.sv
// rtl/load_store_unit_addr_gen.sv - effective address adder with size/alignment flags
// Alignment checking is compiled in only when LSU_ALIGN_CHECK_EN is defined.
module load_store_unit_addr_gen
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_offset,
    input  logic [1:0]        i_size,
    output logic [ADDR_W-1:0] o_ea,
    output logic              o_size_inv,
    output logic              o_misalign
);

    logic [ADDR_W-1:0] w_ea;

    // Carry out of the top bit is dropped: address arithmetic wraps
    assign w_ea       = i_base + i_offset;
    assign o_ea       = w_ea;
    assign o_size_inv = (i_size == SZ_INV);

`ifdef LSU_ALIGN_CHECK_EN
    assign o_misalign = ((i_size == SZ_HALF) && w_ea[0]) ||
                        ((i_size == SZ_WORD) && (w_ea[1:0] != 2'b00));
`else
    assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit between execute and data memory
// Optional alignment checking: LSU_ALIGN_CHECK_EN (see load_store_unit_addr_gen).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signext,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mem_load,
    output logic              mem_store,
    output logic [1:0]        mem_size,
    output logic              mem_signext,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_is_load,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [TAG_W-1:0]  rsp_tag
);

    lsu_state_t        r_state;
    logic [1:0]        r_size;
    logic              r_signext;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_err;
    logic              r_rsp_is_load;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [TAG_W-1:0]  r_rsp_tag;

    logic [ADDR_W-1:0] w_ea;
    logic              w_size_inv;
    logic              w_misalign;
    logic              w_accept;

    load_store_unit_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .i_base     (req_base),
        .i_offset   (req_offset),
        .i_size     (req_size),
        .o_ea       (w_ea),
        .o_size_inv (w_size_inv),
        .o_misalign (w_misalign)
    );

    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_size        <= '0;
            r_signext     <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_is_load <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_tag     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_size        <= req_size;
                        r_signext     <= req_signext;
                        r_addr        <= w_ea;
                        r_wdata       <= req_wdata;
                        r_rsp_tag     <= req_tag;
                        r_rsp_is_load <= !req_we;
                        r_rsp_rdata   <= '0;
                        // Rejected requests skip memory entirely and answer next cycle
                        if (w_size_inv || w_misalign) begin
                            r_rsp_err <= 1'b1;
                            r_state   <= ST_RESP;
                        end else begin
                            r_rsp_err <= 1'b0;
                            r_state   <= req_we ? ST_ISSUE_ST : ST_ISSUE_LD;
                        end
                    end
                end
                ST_ISSUE_LD: r_state <= ST_WAIT_LD;
                ST_WAIT_LD: begin
                    r_rsp_rdata <= mem_dout;
                    r_state     <= ST_RESP;
                end
                ST_ISSUE_ST: r_state <= ST_RESP;
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state       <= ST_IDLE;
                        r_rsp_err     <= 1'b0;
                        r_rsp_is_load <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_tag     <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are gated by rst so an abandoned store never commits on the reset edge
    assign mem_load    = (r_state == ST_ISSUE_LD) && !rst;
    assign mem_store   = (r_state == ST_ISSUE_ST) && !rst;
    assign mem_size    = r_size;
    assign mem_signext = r_signext;
    assign mem_addr    = r_addr;
    assign mem_din     = r_wdata;

    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_is_load = r_rsp_is_load;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_tag     = r_rsp_tag;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit with byte-array memory
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signext;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        mem_load;
    logic        mem_store;
    logic [1:0]  mem_size;
    logic        mem_signext;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_is_load;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_tag;

    int checks = 0;
    int errors = 0;
    int ld_pulses = 0;
    int st_pulses = 0;
    logic [31:0] mon_addr = 32'h0;

    logic [7:0] dev_mem [bit [31:0]];
    logic [7:0] ref_mem [bit [31:0]];
    logic [31:0] dev_raw;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32), .TAG_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signext (req_signext),
        .req_base    (req_base),
        .req_offset  (req_offset),
        .req_wdata   (req_wdata),
        .req_tag     (req_tag),
        .mem_load    (mem_load),
        .mem_store   (mem_store),
        .mem_size    (mem_size),
        .mem_signext (mem_signext),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_is_load (rsp_is_load),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .rsp_tag     (rsp_tag)
    );

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz, input logic sx);
        case (sz)
            2'b00:   return sx ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            2'b01:   return sx ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Little-endian byte-addressed memory device on the far side of the LSU
    always @(posedge clk) begin
        mem_dout <= 32'h0;
        if (mem_store)
            for (int i = 0; i < nbytes(mem_size); i++)
                dev_mem[mem_addr + 32'(i)] = mem_din[8*i +: 8];
        if (mem_load) begin
            dev_raw = 32'h0;
            for (int i = 0; i < nbytes(mem_size); i++)
                if (dev_mem.exists(mem_addr + 32'(i)))
                    dev_raw[8*i +: 8] = dev_mem[mem_addr + 32'(i)];
            mem_dout <= extend(dev_raw, mem_size, mem_signext);
        end
    end

    always @(negedge clk) begin
        if (mem_load) begin
            ld_pulses = ld_pulses + 1;
            mon_addr  = mem_addr;
        end
        if (mem_store) begin
            st_pulses = st_pulses + 1;
            mon_addr  = mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] ea);
        if (sz == 2'b11) return 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
        if (sz == 2'b01 && ea[0]) return 1'b1;
        if (sz == 2'b10 && ea[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] ea, input logic [1:0] sz, input logic sx);
        logic [31:0] raw = 32'h0;
        for (int i = 0; i < nbytes(sz); i++)
            if (ref_mem.exists(ea + 32'(i)))
                raw[8*i +: 8] = ref_mem[ea + 32'(i)];
        return extend(raw, sz, sx);
    endfunction

    task automatic ref_store(input logic [31:0] ea, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++)
            ref_mem[ea + 32'(i)] = wd[8*i +: 8];
    endtask

    task automatic txn(input logic we, input logic [1:0] sz, input logic sx, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd, input logic [4:0] tag, input int hold);
        logic [31:0] ea;
        logic        err;
        logic [31:0] exp_rdata;
        int          lat;
        int          n;
        ea        = base + off;
        err       = exp_err(sz, ea);
        exp_rdata = (err || we) ? 32'h0 : ref_load(ea, sz, sx);
        @(negedge clk);
        ld_pulses   = 0;
        st_pulses   = 0;
        req_we      = we;
        req_size    = sz;
        req_signext = sx;
        req_base    = base;
        req_offset  = off;
        req_wdata   = wd;
        req_tag     = tag;
        req_valid   = 1'b1;
        rsp_ready   = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_base   = $urandom;
        req_offset = $urandom;
        req_wdata  = $urandom;
        req_size   = 2'(req_size + 2'd1);
        req_tag    = 5'(req_tag + 5'd1);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        #1;
        check("latency", 32'(lat), err ? 32'd1 : (we ? 32'd2 : 32'd3));
        check("rsp_err", 32'(rsp_err), 32'(err));
        check("rsp_is_load", 32'(rsp_is_load), 32'(!we));
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_tag", 32'(rsp_tag), 32'(tag));
        check("ld_pulses", 32'(ld_pulses), (!err && !we) ? 32'd1 : 32'd0);
        check("st_pulses", 32'(st_pulses), (!err && we) ? 32'd1 : 32'd0);
        if (!err) check("mem_addr", mon_addr, ea);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'h1);
            check("hold_req_ready", 32'(req_ready), 32'h0);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_tag", 32'(rsp_tag), 32'(tag));
            check("hold_err", 32'(rsp_err), 32'(err));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("retire_valid", 32'(rsp_valid), 32'h0);
        check("retire_req_ready", 32'(req_ready), 32'h1);
        if (we && !err) ref_store(ea, sz, wd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signext = 1'b0;
        req_base = 32'h0; req_offset = 32'h0; req_wdata = 32'h0; req_tag = 5'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mem_strobes", {30'h0, mem_load, mem_store}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_din", mem_din, 32'h0);
        check("rst_mem_ctl", {29'h0, mem_size, mem_signext}, 32'h0);
        check("rst_rsp_fields", {25'h0, rsp_err, rsp_is_load, rsp_tag}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'h1);

        txn(1'b1, 2'b10, 1'b0, 32'h100, 32'h4, 32'hDEADBEEF, 5'd1, 0);
        txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h4, 32'h0, 5'd2, 0);
        txn(1'b1, 2'b00, 1'b0, 32'h20, 32'h0, 32'h00000080, 5'd3, 0);
        txn(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h0, 5'd4, 0);
        txn(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h0, 5'd5, 0);
        txn(1'b0, 2'b01, 1'b1, 32'h100, 32'h3, 32'h0, 5'd6, 0);
        txn(1'b1, 2'b11, 1'b0, 32'h100, 32'h4, 32'h12345678, 5'd7, 0);
        txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h4, 32'h0, 5'd8, 0);
        txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h4, 32'h0, 5'd9, 5);
        txn(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h8, 32'hA5A55A5A, 5'd10, 1);
        txn(1'b0, 2'b01, 1'b1, 32'h2, 32'h2, 32'h0, 5'd11, 0);

        // Reset lands while the store strobe is up: nothing may commit
        @(negedge clk);
        st_pulses = 0;
        req_we = 1'b1; req_size = 2'b10; req_signext = 1'b0;
        req_base = 32'h300; req_offset = 32'h0; req_wdata = 32'hCAFEBABE; req_tag = 5'd12;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rst_mid_mem_store", 32'(mem_store), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_st_pulses", 32'(st_pulses), 32'h0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_req_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_after", 32'(req_ready), 32'h1);
        check("rst_mid_rsp_after", 32'(rsp_valid), 32'h0);
        txn(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0, 5'd13, 0);

        for (int k = 0; k < 150; k++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                32'h200 + 32'($urandom_range(0, 31)), 32'($urandom_range(0, 15)) - 32'd8,
                $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
